// File: rtl/la_capture_ctrl.sv
// -----------------------------------------------------------------------------
// la_capture_ctrl
//
// Capture sequencer for the logic-analyzer sample buffer (2^AW x DW dual-port
// RAM). It runs arm -> pre-trigger fill -> trigger search -> post-trigger fill,
// and drives the RAM write port one clock after each accepted sample strobe.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   sample_en, din  sample strobe and channel sample
//   arm, abort      start / cancel a capture (abort wins over arm)
//   force_trig      trigger on the next sample while searching
//   pre_num         pre-trigger sample count, latched on arm
//   trig_mask/val   per-channel participation and level/edge polarity
//   trig_edge       0 = level match, 1 = edge match
//   wr_en/addr/data RAM write port (registered, 1 clk after sample_en)
//   start_addr      buffer address of the trigger sample
//   trigger_en      capture busy (PRE, WAIT_TRIG, POST)
//   done            one-cycle pulse when a capture completes
//   state           current state code for CPU status
// -----------------------------------------------------------------------------
module la_capture_ctrl #(
  parameter int DW = 8,
  parameter int AW = 10
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          sample_en,
  input  logic [DW-1:0] din,
  input  logic          arm,
  input  logic          abort,
  input  logic          force_trig,
  input  logic [AW-1:0] pre_num,
  input  logic [DW-1:0] trig_mask,
  input  logic [DW-1:0] trig_val,
  input  logic          trig_edge,
  output logic          wr_en,
  output logic [AW-1:0] wr_addr,
  output logic [DW-1:0] wr_data,
  output logic [AW-1:0] start_addr,
  output logic          trigger_en,
  output logic          done,
  output logic [2:0]    state
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    PRE       = 3'd1,
    WAIT_TRIG = 3'd2,
    POST      = 3'd3,
    DONE      = 3'd4
  } state_t;

  state_t state_q, state_d;

  // Capture configuration latched on arm.
  logic [AW-1:0] pre_num_q;
  logic [DW-1:0] mask_q, val_q;
  logic          edge_q;

  // Sequencing state.
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] pre_cnt;
  logic [AW:0]   post_cnt;
  logic [DW-1:0] din_prev;
  logic          prev_valid;
  logic          force_pend;

  logic          active, do_arm, do_write;
  logic          level_hit, edge_hit, hit;
  logic [AW-1:0] pre_cnt_inc;
  logic [AW:0]   post_cnt_inc, post_target;

  assign active   = (state_q == PRE) || (state_q == WAIT_TRIG) || (state_q == POST);
  assign do_arm   = arm && !abort && ((state_q == IDLE) || (state_q == DONE));
  // A sample arriving with abort is dropped.
  assign do_write = sample_en && active && !abort;

  assign pre_cnt_inc  = pre_cnt + AW'(1);
  assign post_cnt_inc = post_cnt + (AW+1)'(1);
  // Post-trigger length including the trigger sample: 2^AW - pre_num, 1..2^AW.
  assign post_target  = {1'b1, {AW{1'b0}}} - {1'b0, pre_num_q};

  assign level_hit = ((din ^ val_q) & mask_q) == '0;
  assign edge_hit  = level_hit && prev_valid && (((din ^ din_prev) & mask_q) != '0);
  // An empty mask matches immediately in both modes; a pending or same-cycle
  // force_trig turns the current sample into the trigger sample.
  assign hit = (mask_q == '0) || force_pend || force_trig ||
               (edge_q ? edge_hit : level_hit);

  assign trigger_en = active;
  assign state      = state_q;

  // Next-state logic.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    state_d = state_q;
    if (abort) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE, DONE: if (arm) state_d = (pre_num == '0) ? WAIT_TRIG : PRE;
        PRE:        if (sample_en && (pre_cnt_inc == pre_num_q)) state_d = WAIT_TRIG;
        WAIT_TRIG:  if (sample_en && hit)
                      state_d = (post_target == (AW+1)'(1)) ? DONE : POST;
        POST:       if (sample_en && (post_cnt_inc == post_target)) state_d = DONE;
        default:    state_d = IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values of the others.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Datapath: write port, counters, trigger history and configuration.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      start_addr <= '0;
      done       <= 1'b0;
      wr_ptr     <= '0;
      pre_cnt    <= '0;
      post_cnt   <= '0;
      din_prev   <= '0;
      prev_valid <= 1'b0;
      force_pend <= 1'b0;
      pre_num_q  <= '0;
      mask_q     <= '0;
      val_q      <= '0;
      edge_q     <= 1'b0;
    end else begin
      wr_en <= do_write;
      done  <= (state_d == DONE) && (state_q != DONE);

      if (do_write) begin
        wr_data    <= din;
        wr_addr    <= wr_ptr;
        wr_ptr     <= wr_ptr + AW'(1);
        din_prev   <= din;
        prev_valid <= 1'b1;
      end

      if (do_arm) begin
        pre_num_q  <= pre_num;
        mask_q     <= trig_mask;
        val_q      <= trig_val;
        edge_q     <= trig_edge;
        wr_ptr     <= '0;
        wr_addr    <= '0;
        pre_cnt    <= '0;
        post_cnt   <= '0;
        prev_valid <= 1'b0;
        force_pend <= 1'b0;
      end

      case (state_q)
        PRE: if (do_write) pre_cnt <= pre_cnt_inc;
        WAIT_TRIG: begin
          if (do_write) begin
            force_pend <= 1'b0;
            if (hit) begin
              start_addr <= wr_ptr;
              post_cnt   <= (AW+1)'(1);
            end
          end else if (force_trig) begin
            force_pend <= 1'b1;
          end
        end
        POST: if (do_write) post_cnt <= post_cnt_inc;
        default: ;
      endcase

      if (abort) force_pend <= 1'b0;
    end
  end

endmodule

// File: tb/tb_la_capture_ctrl.sv
`timescale 1ns/1ps
module tb_la_capture_ctrl;
  localparam int DW = 8;
  localparam int AW = 10;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          sample_en = 1'b0;
  logic [DW-1:0] din = '0;
  logic          arm = 1'b0;
  logic          abort = 1'b0;
  logic          force_trig = 1'b0;
  logic [AW-1:0] pre_num = '0;
  logic [DW-1:0] trig_mask = '0;
  logic [DW-1:0] trig_val = '0;
  logic          trig_edge = 1'b0;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic [AW-1:0] start_addr;
  logic          trigger_en;
  logic          done;
  logic [2:0]    state;

  la_capture_ctrl #(.DW(DW), .AW(AW)) dut (
    .clk(clk), .rst(rst), .sample_en(sample_en), .din(din),
    .arm(arm), .abort(abort), .force_trig(force_trig), .pre_num(pre_num),
    .trig_mask(trig_mask), .trig_val(trig_val), .trig_edge(trig_edge),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .start_addr(start_addr), .trigger_en(trigger_en), .done(done),
    .state(state)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;

  wr_t           sb_q[$];
  int            checks = 0;
  int            errors = 0;
  int            done_cnt = 0;
  logic [AW-1:0] exp_ptr = '0;

  // One clock: drive inputs, push the expected write, then after the edge pop
  // and compare the write port. Pulse inputs are released after every edge.
  task automatic tick(input logic se, input logic [DW-1:0] d, input logic exp_wr);
    wr_t e;
    sample_en = se;
    din       = d;
    if (exp_wr) begin
      e.addr = exp_ptr;
      e.data = d;
      sb_q.push_back(e);
      exp_ptr = exp_ptr + AW'(1);
    end
    @(posedge clk);
    #1;
    sample_en  = 1'b0;
    arm        = 1'b0;
    abort      = 1'b0;
    force_trig = 1'b0;
    if (done === 1'b1) done_cnt++;
    checks++;
    if (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      if (wr_en !== 1'b1 || wr_addr !== e.addr || wr_data !== e.data) begin
        errors++;
        $display("FAIL write: got wr_en=%b addr=%0d data=%h, want wr_en=1 addr=%0d data=%h",
                 wr_en, wr_addr, wr_data, e.addr, e.data);
      end
    end else if (wr_en !== 1'b0) begin
      errors++;
      $display("FAIL stray_write: got wr_en=%b addr=%0d, want wr_en=0", wr_en, wr_addr);
    end
  endtask

  task automatic arm_capture(input logic [AW-1:0] pn, input logic [DW-1:0] m,
                             input logic [DW-1:0] v, input logic e,
                             input logic [2:0] exp_state);
    pre_num   = pn;
    trig_mask = m;
    trig_val  = v;
    trig_edge = e;
    arm       = 1'b1;
    exp_ptr   = '0;
    done_cnt  = 0;
    tick(1'b0, '0, 1'b0);
    checks++;
    if (state !== exp_state || trigger_en !== 1'b1) begin
      errors++;
      $display("FAIL arm: got state=%0d trigger_en=%b, want state=%0d trigger_en=1",
               state, trigger_en, exp_state);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(1'b0, '0, 1'b0);
    tick(1'b1, 8'h3c, 1'b0);
    checks++;
    if ({wr_en, wr_addr, wr_data, start_addr, trigger_en, done, state} !== '0) begin
      errors++;
      $display("FAIL reset: got en=%b addr=%0d data=%h start=%0d busy=%b done=%b state=%0d, want all 0",
               wr_en, wr_addr, wr_data, start_addr, trigger_en, done, state);
    end
    rst = 1'b0;
    tick(1'b0, '0, 1'b0);
  endtask

  // Level trigger on bit 0 after 100 pre-trigger samples; trigger at sample 300.
  task automatic test_level();
    arm_capture(AW'(100), 8'h01, 8'h01, 1'b0, 3'd1);
    for (int i = 0; i < 300; i++) begin
      tick(1'b1, 8'(2 * i), 1'b1);
      if (i == 98) begin
        checks++;
        if (state !== 3'd1) begin errors++; $display("FAIL level_pre: got state=%0d, want 1", state); end
      end
      if (i == 99) begin
        checks++;
        if (state !== 3'd2) begin errors++; $display("FAIL level_pre_exit: got state=%0d, want 2", state); end
      end
    end
    tick(1'b1, 8'h01, 1'b1);
    checks++;
    if (state !== 3'd3 || start_addr !== AW'(300)) begin
      errors++;
      $display("FAIL level_hit: got state=%0d start=%0d, want 3 / 300", state, start_addr);
    end
    for (int k = 1; k < 924; k++) tick(1'b1, 8'(2 * k), 1'b1);
    checks++;
    if (state !== 3'd4 || done !== 1'b1 || wr_addr !== AW'(199)) begin
      errors++;
      $display("FAIL level_end: got state=%0d done=%b last_addr=%0d, want 4 / 1 / 199",
               state, done, wr_addr);
    end
    tick(1'b0, '0, 1'b0);
    checks++;
    if (done !== 1'b0 || trigger_en !== 1'b0 || start_addr !== AW'(300) || done_cnt != 1) begin
      errors++;
      $display("FAIL level_after: got done=%b busy=%b start=%0d pulses=%0d, want 0 / 0 / 300 / 1",
               done, trigger_en, start_addr, done_cnt);
    end
  endtask

  // pre_num=0, empty mask: first sample triggers, full 1024-sample buffer.
  task automatic test_mask0();
    arm_capture('0, 8'h00, 8'h00, 1'b0, 3'd2);
    for (int i = 0; i < 1024; i++) begin
      tick(1'b1, 8'(i * 7), 1'b1);
      if (i == 0) begin
        checks++;
        if (state !== 3'd3 || start_addr !== '0) begin
          errors++;
          $display("FAIL mask0_hit: got state=%0d start=%0d, want 3 / 0", state, start_addr);
        end
      end
    end
    checks++;
    if (state !== 3'd4 || done !== 1'b1 || wr_addr !== AW'(1023) || done_cnt != 1) begin
      errors++;
      $display("FAIL mask0_end: got state=%0d done=%b last_addr=%0d pulses=%0d, want 4 / 1 / 1023 / 1",
               state, done, wr_addr, done_cnt);
    end
    tick(1'b1, 8'haa, 1'b0);
    checks++;
    if (start_addr !== '0 || done !== 1'b0) begin
      errors++;
      $display("FAIL mask0_hold: got start=%0d done=%b, want 0 / 0", start_addr, done);
    end
  endtask

  // Edge trigger on bit 7 rising; then abort in POST together with a sample.
  task automatic test_edge();
    arm_capture(AW'(10), 8'h80, 8'h80, 1'b1, 3'd1);
    for (int i = 0; i < 49; i++) tick(1'b1, 8'h80, 1'b1);
    checks++;
    if (state !== 3'd2) begin errors++; $display("FAIL edge_held: got state=%0d, want 2", state); end
    tick(1'b1, 8'h00, 1'b1);
    checks++;
    if (state !== 3'd2) begin errors++; $display("FAIL edge_low: got state=%0d, want 2", state); end
    tick(1'b1, 8'h80, 1'b1);
    checks++;
    if (state !== 3'd3 || start_addr !== AW'(50)) begin
      errors++;
      $display("FAIL edge_hit: got state=%0d start=%0d, want 3 / 50", state, start_addr);
    end
    abort = 1'b1;
    tick(1'b1, 8'h55, 1'b0);
    checks++;
    if (state !== 3'd0 || trigger_en !== 1'b0 || start_addr !== AW'(50) || done !== 1'b0) begin
      errors++;
      $display("FAIL edge_abort: got state=%0d busy=%b start=%0d done=%b, want 0 / 0 / 50 / 0",
               state, trigger_en, start_addr, done);
    end
    tick(1'b1, 8'h66, 1'b0);
  endtask

  // Abort during WAIT_TRIG at sample 500; abort beats a simultaneous arm.
  task automatic test_abort();
    arm_capture(AW'(10), 8'h01, 8'h01, 1'b0, 3'd1);
    for (int i = 0; i < 500; i++) tick(1'b1, 8'(2 * i), 1'b1);
    checks++;
    if (state !== 3'd2) begin errors++; $display("FAIL abort_wait: got state=%0d, want 2", state); end
    abort = 1'b1;
    tick(1'b1, 8'h10, 1'b0);
    checks++;
    if (state !== 3'd0 || start_addr !== AW'(50) || done !== 1'b0) begin
      errors++;
      $display("FAIL abort: got state=%0d start=%0d done=%b, want 0 / 50 / 0", state, start_addr, done);
    end
    for (int i = 0; i < 3; i++) tick(1'b1, 8'h20, 1'b0);
    abort = 1'b1;
    arm   = 1'b1;
    tick(1'b0, '0, 1'b0);
    checks++;
    if (state !== 3'd0 || trigger_en !== 1'b0 || done_cnt != 0) begin
      errors++;
      $display("FAIL abort_arm: got state=%0d busy=%b pulses=%0d, want 0 / 0 / 0",
               state, trigger_en, done_cnt);
    end
  endtask

  // Re-arm restarts at address 0; force_trig with a never-matching mask; arm
  // during POST is ignored; strobes every 4th cycle; pointer wraps.
  task automatic test_force_arm_ignore();
    arm_capture(AW'(5), 8'h01, 8'h01, 1'b0, 3'd1);
    for (int i = 0; i < 20; i++) tick(1'b1, 8'(2 * i), 1'b1);
    force_trig = 1'b1;
    tick(1'b0, '0, 1'b0);
    tick(1'b0, '0, 1'b0);
    checks++;
    if (state !== 3'd2) begin errors++; $display("FAIL force_wait: got state=%0d, want 2", state); end
    tick(1'b1, 8'h40, 1'b1);
    checks++;
    if (state !== 3'd3 || start_addr !== AW'(20)) begin
      errors++;
      $display("FAIL force_hit: got state=%0d start=%0d, want 3 / 20", state, start_addr);
    end
    for (int k = 1; k < 1019; k++) begin
      for (int j = 0; j < 3; j++) tick(1'b0, 8'hff, 1'b0);
      if (k == 500) begin
        arm     = 1'b1;
        pre_num = '0;
      end
      tick(1'b1, 8'(3 * k), 1'b1);
      if (k == 500) begin
        checks++;
        if (state !== 3'd3 || trigger_en !== 1'b1) begin
          errors++;
          $display("FAIL arm_in_post: got state=%0d busy=%b, want 3 / 1", state, trigger_en);
        end
      end
    end
    checks++;
    if (state !== 3'd4 || done !== 1'b1 || wr_addr !== AW'(14) || done_cnt != 1) begin
      errors++;
      $display("FAIL force_end: got state=%0d done=%b last_addr=%0d pulses=%0d, want 4 / 1 / 14 / 1",
               state, done, wr_addr, done_cnt);
    end
  endtask

  // Reset asserted mid-POST together with a sample strobe.
  task automatic test_rst_mid_post();
    arm_capture('0, 8'h00, 8'h00, 1'b0, 3'd2);
    tick(1'b1, 8'h11, 1'b1);
    for (int k = 0; k < 5; k++) begin
      for (int j = 0; j < 3; j++) tick(1'b0, '0, 1'b0);
      tick(1'b1, 8'(k + 8'h20), 1'b1);
    end
    checks++;
    if (state !== 3'd3) begin errors++; $display("FAIL rst_pre: got state=%0d, want 3", state); end
    rst = 1'b1;
    tick(1'b1, 8'h77, 1'b0);
    checks++;
    if ({wr_en, wr_addr, wr_data, start_addr, trigger_en, done, state} !== '0) begin
      errors++;
      $display("FAIL rst_mid_post: got en=%b addr=%0d data=%h start=%0d busy=%b done=%b state=%0d, want all 0",
               wr_en, wr_addr, wr_data, start_addr, trigger_en, done, state);
    end
    rst = 1'b0;
    tick(1'b1, 8'h78, 1'b0);
  endtask

  initial begin
    test_reset();
    test_level();
    test_mask0();
    test_edge();
    test_abort();
    test_force_arm_ignore();
    test_rst_mid_post();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule
